// File: rtl/mfp_ahb_lite_uart16550_txseq.sv
// mfp_ahb_lite_uart16550_txseq: AHB-Lite master that configures a 16550 UART and streams
// bytes from a local FIFO into its THR, pacing writes with LSR polls and a burst credit.
`timescale 1ns/1ps
module mfp_ahb_lite_uart16550_txseq #(
    parameter logic [31:0] BASE_ADDR = 32'h1F00_0000,
    parameter logic [15:0] DIVISOR   = 16'd27,
    parameter logic [7:0]  LCR_VALUE = 8'h03,
    parameter int          FIFO_AW   = 3
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    output logic [31:0]        HADDR,
    output logic [2:0]         HBURST,
    output logic               HMASTLOCK,
    output logic [3:0]         HPROT,
    output logic [2:0]         HSIZE,
    output logic [1:0]         HTRANS,
    output logic               HWRITE,
    output logic [31:0]        HWDATA,
    input  logic [31:0]        HRDATA,
    input  logic               HREADY,
    input  logic               HRESP,
    input  logic [7:0]         tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               init_done,
    output logic               busy,
    output logic               bus_err,
    output logic [FIFO_AW:0]   fifo_level
);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {S_CFG, S_IDLE, S_POLL, S_THR} state_t;

    state_t           state, state_n;
    logic [2:0]       step, step_n;
    logic [4:0]       credit, credit_n;
    logic             init_n, aph, dph, issue, done, pop, push, more, empty, full, wr;
    logic [7:0]       off, wbyte, cfg_off, cfg_byte, head;
    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wptr, rptr;
    logic             unused_hrdata;

    assign HBURST        = 3'b000;
    assign HMASTLOCK     = 1'b0;
    assign HPROT         = 4'b0011;
    assign HSIZE         = 3'b010;
    assign HTRANS        = {aph, 1'b0};
    assign unused_hrdata = ^{HRDATA[31:6], HRDATA[4:0]};

    assign fifo_level = wptr - rptr;
    assign empty      = wptr == rptr;
    assign full       = fifo_level[FIFO_AW];
    assign tx_ready   = !full;
    assign push       = tx_valid && !full;
    assign head       = mem[rptr[FIFO_AW-1:0]];
    assign busy       = state != S_IDLE || !empty;
    assign done       = dph && HREADY;
    // FIFO still holds a byte after the current pop
    assign more       = fifo_level > (FIFO_AW+1)'(1) || push;

    always_ff @(posedge HCLK)
        if (push) mem[wptr[FIFO_AW-1:0]] <= tx_data;

    always_comb begin
        cfg_off  = 8'h08;
        cfg_byte = 8'h07;
        case (step)
            3'd0: begin cfg_off = 8'h0C; cfg_byte = 8'h80 | LCR_VALUE; end
            3'd1: begin cfg_off = 8'h00; cfg_byte = DIVISOR[7:0];      end
            3'd2: begin cfg_off = 8'h04; cfg_byte = DIVISOR[15:8];     end
            3'd3: begin cfg_off = 8'h0C; cfg_byte = LCR_VALUE;         end
            default: ;
        endcase
    end

    always_comb begin
        state_n  = state;
        step_n   = step;
        credit_n = credit;
        init_n   = init_done;
        pop      = 1'b0;
        issue    = !aph && !dph && state != S_IDLE;
        wr       = state != S_POLL;
        off      = state == S_CFG ? cfg_off : state == S_POLL ? 8'h14 : 8'h00;
        wbyte    = state == S_CFG ? cfg_byte : head;
        unique case (state)
            S_CFG:
                if (done) begin
                    step_n = step + 3'd1;
                    if (step == 3'd4) begin
                        state_n = S_IDLE;
                        init_n  = 1'b1;
                    end
                end
            S_IDLE:
                if (!empty) state_n = credit != 5'd0 ? S_THR : S_POLL;
            S_POLL:
                if (done && !HRESP && HRDATA[5]) begin
                    credit_n = 5'd16;
                    state_n  = S_THR;
                end
            S_THR:
                if (done) begin
                    pop      = 1'b1;
                    credit_n = credit - 5'd1;
                    state_n  = !more ? S_IDLE : credit_n != 5'd0 ? S_THR : S_POLL;
                end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= S_CFG;
            step      <= 3'd0;
            credit    <= 5'd0;
            init_done <= 1'b0;
            bus_err   <= 1'b0;
            aph       <= 1'b0;
            dph       <= 1'b0;
            wptr      <= '0;
            rptr      <= '0;
            HADDR     <= BASE_ADDR;
            HWRITE    <= 1'b0;
            HWDATA    <= 32'h0;
        end else begin
            state     <= state_n;
            step      <= step_n;
            credit    <= credit_n;
            init_done <= init_n;
            bus_err   <= bus_err | (done & HRESP);
            aph       <= issue;
            dph       <= aph | (dph & !HREADY);
            wptr      <= wptr + (FIFO_AW+1)'(push);
            rptr      <= rptr + (FIFO_AW+1)'(pop);
            if (issue) begin
                HADDR  <= BASE_ADDR + {24'h0, off};
                HWRITE <= wr;
                HWDATA <= {24'h0, wr ? wbyte : 8'h00};
            end
        end
    end
endmodule

// File: tb/tb_mfp_ahb_lite_uart16550_txseq.sv
// tb_mfp_ahb_lite_uart16550_txseq: directed bench with a one-wait-state UART slave model
// that logs every completed transfer for comparison against hand-built expected logs.
`timescale 1ns/1ps
module tb_mfp_ahb_lite_uart16550_txseq;
    localparam logic [31:0] BASE = 32'h1F00_0000;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [31:0] HADDR, HWDATA;
    logic [31:0] HRDATA = 32'h0;
    logic [2:0]  HBURST, HSIZE;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK, HWRITE;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready, init_done, busy, bus_err;
    logic [3:0]  fifo_level;

    int tests = 0;
    int fails = 0;
    logic [64:0] logq[$];
    logic [64:0] expq[$];
    logic [7:0]  lsrq[$];
    bit stall = 0, err_once = 0, pend = 0, wseen = 0;

    mfp_ahb_lite_uart16550_txseq dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HBURST(HBURST),
        .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HSIZE(HSIZE), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
        .HRESP(HRESP), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .init_done(init_done), .busy(busy), .bus_err(bus_err), .fifo_level(fifo_level)
    );

    always #5 HCLK = ~HCLK;

    // Slave: one wait cycle per data phase (more while stalled), LSR reads from lsrq or 0x60
    always @(posedge HCLK) begin
        #1;
        if (!HRESETn) begin
            pend = 0; HREADY = 1; HRESP = 0;
        end else if (HTRANS == 2'b10) begin
            pend = 1; wseen = 0; HREADY = 1; HRESP = 0;
        end else if (pend && (!wseen || stall)) begin
            wseen = 1; HREADY = 0;
        end else if (pend) begin
            HREADY = 1; HRESP = err_once; err_once = 0;
            HRDATA = 32'h60;
            if (!HWRITE && lsrq.size() > 0) HRDATA = {24'h0, lsrq.pop_front()};
            logq.push_back({HWRITE, HADDR, HWRITE ? HWDATA : 32'h0});
            pend = 0;
        end else begin
            HREADY = 1; HRESP = 0;
        end
    end

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ex(input logic w, input logic [7:0] off, input logic [7:0] d);
        expq.push_back({w, BASE + {24'h0, off}, {24'h0, d}});
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_len"}, 65'(logq.size()), 65'(expq.size()));
        for (int i = 0; i < expq.size() && i < logq.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), logq[i], expq[i]);
        logq.delete();
        expq.delete();
    endtask

    task automatic push(input logic [7:0] b);
        int n = 0;
        tx_data = b; tx_valid = 1;
        while (!tx_ready && n < 300) begin @(negedge HCLK); n++; end
        chk("push_ready", 65'(tx_ready), 65'(1));
        @(negedge HCLK);
        tx_valid = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 600) begin @(negedge HCLK); n++; end
        chk(tag, 65'(busy), 65'(0));
    endtask

    task automatic release_and_config(input string tag);
        int n = 1;
        @(negedge HCLK);
        HRESETn = 1;
        @(negedge HCLK);
        chk({tag, "_first_aph"}, {HTRANS, HWRITE, HADDR, HWDATA}, {2'b10, 1'b1, BASE + 32'hC, 32'h83});
        while (!init_done && n < 80) begin @(negedge HCLK); n++; end
        chk({tag, "_init_cycle"}, 65'(n), 65'(20));
        ex(1, 8'h0C, 8'h83); ex(1, 8'h00, 8'h1B); ex(1, 8'h04, 8'h00);
        ex(1, 8'h0C, 8'h03); ex(1, 8'h08, 8'h07);
        check_log(tag);
    endtask

    initial begin
        repeat (2) @(negedge HCLK);
        chk("rst_htrans", 65'(HTRANS), 65'(0));
        chk("rst_haddr", 65'(HADDR), 65'(BASE));
        chk("rst_hwrite_hwdata", {HWRITE, HWDATA}, 65'(0));
        chk("rst_flags", {init_done, bus_err, busy, tx_ready}, 65'(4'b0011));
        chk("rst_level", 65'(fifo_level), 65'(0));
        chk("const_ctl", {HBURST, HMASTLOCK, HPROT, HSIZE}, 65'({3'b000, 1'b0, 4'b0011, 3'b010}));

        release_and_config("cfg");

        // single byte: credit starts at 0, so one LSR poll precedes the write
        push(8'h41);
        wait_idle("single_idle");
        ex(0, 8'h14, 8'h00); ex(1, 8'h00, 8'h41);
        check_log("single");

        // 20 bytes with 15 credits left over: 15 writes, poll, 5 writes
        for (int i = 0; i < 20; i++) push(8'(i));
        wait_idle("credit_idle");
        for (int i = 0; i < 15; i++) ex(1, 8'h00, 8'(i));
        ex(0, 8'h14, 8'h00);
        for (int i = 15; i < 20; i++) ex(1, 8'h00, 8'(i));
        check_log("credit");

        // 11 credits left; the 12th byte waits for three THRE=0 polls
        lsrq.push_back(8'h00); lsrq.push_back(8'h00); lsrq.push_back(8'h00); lsrq.push_back(8'h60);
        for (int i = 0; i < 12; i++) push(8'h80 + 8'(i));
        wait_idle("thre_idle");
        for (int i = 0; i < 11; i++) ex(1, 8'h00, 8'h80 + 8'(i));
        repeat (4) ex(0, 8'h14, 8'h00);
        ex(1, 8'h00, 8'h8B);
        check_log("thre");

        // error response on a THR write drops that byte and sets bus_err
        chk("bus_err_clear", 65'(bus_err), 65'(0));
        err_once = 1;
        push(8'h55);
        push(8'h66);
        wait_idle("err_idle");
        chk("bus_err_set", 65'(bus_err), 65'(1));
        ex(1, 8'h00, 8'h55); ex(1, 8'h00, 8'h66);
        check_log("err");
        chk("err_level", 65'(fifo_level), 65'(0));

        // backpressure: stalled slave lets the FIFO fill to 8
        stall = 1;
        for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
        chk("bp_level", 65'(fifo_level), 65'(8));
        chk("bp_ready", 65'(tx_ready), 65'(0));
        stall = 0;
        push(8'hA8);
        wait_idle("bp_idle");
        for (int i = 0; i < 9; i++) ex(1, 8'h00, 8'hA0 + 8'(i));
        check_log("bp");

        // reset during a stalled THR data phase
        stall = 1;
        push(8'hC0);
        push(8'hC1);
        repeat (4) @(negedge HCLK);
        chk("mid_dphase", {HTRANS, HWRITE, HADDR, HWDATA}, {2'b00, 1'b1, BASE, 32'hC0});
        #2 HRESETn = 0;
        #1;
        chk("arst_htrans", 65'(HTRANS), 65'(0));
        chk("arst_level", 65'(fifo_level), 65'(0));
        chk("arst_flags", {init_done, bus_err, busy, tx_ready}, 65'(4'b0011));
        chk("arst_haddr", {HWRITE, HADDR, HWDATA}, {1'b0, BASE, 32'h0});
        stall = 0;
        logq.delete();
        release_and_config("recfg");
        chk("recfg_level", 65'(fifo_level), 65'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
